// File: rtl/video_timing_detect_pkg.sv
// Shared definitions for the video timing detector: FSM encoding, measurement
// counter width and the saturating increment used by the line and run counters.
package video_timing_detect_pkg;

    localparam int CNT_W = 12;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } vtd_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/video_edge_det.sv
// One-cycle delay of a video control signal plus rise/fall pulses against it.
// The delayed copy doubles as the pass-through output for that signal.
module video_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic prev,
    output logic rise,
    output logic fall
);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;
    assign fall = ~d & prev;

endmodule

// File: rtl/video_timing_detect.sv
// Measures active width/lines of incoming video frames and reports a locked
// format once LOCK_FRAMES consecutive identical good frames have been seen.
module video_timing_detect
    import video_timing_detect_pkg::*;
#(
    parameter int          LOCK_FRAMES   = 2,
    parameter int unsigned TIMEOUT_CYC   = 2**24,
    parameter logic [15:0] FRAME_CNT_RST = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [23:0]      rgb_in,
    input  logic             de,
    input  logic             hsync,
    input  logic             vsync,
    output logic [23:0]      rgb_out,
    output logic             de_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic [CNT_W-1:0] active_width,
    output logic [CNT_W-1:0] active_lines,
    output logic             stable,
    output logic [15:0]      frame_cnt,
    output logic [1:0]       state
);

    localparam logic [15:0] LOCK_N = 16'(LOCK_FRAMES);

    logic de_rise, de_fall, hs_rise, hs_fall, vs_rise, vs_fall;
    logic unused_edges;

    video_edge_det u_de (.clk(clk), .rst(rst), .d(de),    .prev(de_out),    .rise(de_rise), .fall(de_fall));
    video_edge_det u_hs (.clk(clk), .rst(rst), .d(hsync), .prev(hsync_out), .rise(hs_rise), .fall(hs_fall));
    video_edge_det u_vs (.clk(clk), .rst(rst), .d(vsync), .prev(vsync_out), .rise(vs_rise), .fall(vs_fall));

    assign unused_edges = de_rise ^ hs_rise ^ hs_fall ^ vs_fall;

    vtd_state_t       state_q;
    logic [CNT_W-1:0] run_cnt, line_cnt, width_rec;
    logic [CNT_W-1:0] st_width, st_lines;
    logic             frame_bad;
    logic [15:0]      match_cnt;
    logic [31:0]      to_cnt;

    logic             run_sat, first_fall, fall_bad, fin_bad;
    logic [CNT_W-1:0] fin_width, fin_lines;
    logic             frame_good, frame_same, timeout;
    logic [15:0]      next_match;

    // "fin_*" is the just-ending frame including a DE fall that lands on the boundary.
    always_comb begin
        run_sat    = de && (run_cnt == CNT_MAX);
        first_fall = de_fall && (line_cnt == '0);
        fall_bad   = de_fall && ((line_cnt == CNT_MAX) || (!first_fall && (run_cnt != width_rec)));
        fin_bad    = frame_bad || run_sat || fall_bad;
        fin_width  = first_fall ? run_cnt : width_rec;
        fin_lines  = de_fall ? sat_inc(line_cnt) : line_cnt;
        frame_good = !fin_bad && (fin_width != '0) && (fin_lines != '0);
        frame_same = (fin_width == st_width) && (fin_lines == st_lines);
        next_match = 16'd0;
        if (frame_good && frame_same) begin
            next_match = (match_cnt == 16'hFFFF) ? match_cnt : match_cnt + 16'd1;
        end else if (frame_good) begin
            next_match = 16'd1;
        end
        timeout = !vs_rise && (to_cnt == 32'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out      <= '0;
            run_cnt      <= '0;
            line_cnt     <= '0;
            width_rec    <= '0;
            frame_bad    <= 1'b0;
            st_width     <= '0;
            st_lines     <= '0;
            match_cnt    <= '0;
            to_cnt       <= '0;
            active_width <= '0;
            active_lines <= '0;
            stable       <= 1'b0;
            frame_cnt    <= FRAME_CNT_RST;
            state_q      <= ST_IDLE;
        end else begin
            rgb_out <= rgb_in;

            if (vs_rise) begin
                run_cnt   <= '0;
                line_cnt  <= '0;
                width_rec <= '0;
                frame_bad <= 1'b0;
                frame_cnt <= frame_cnt + 16'd1;
                to_cnt    <= '0;
            end else begin
                run_cnt <= de ? sat_inc(run_cnt) : '0;
                if (run_sat) frame_bad <= 1'b1;
                if (de_fall) begin
                    line_cnt <= sat_inc(line_cnt);
                    if (first_fall) width_rec <= run_cnt;
                    if (fall_bad) frame_bad <= 1'b1;
                end
                to_cnt <= timeout ? '0 : to_cnt + 32'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (vs_rise) begin
                        state_q   <= ST_MEASURE;
                        match_cnt <= '0;
                        st_width  <= '0;
                        st_lines  <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (vs_rise) begin
                        st_width  <= fin_width;
                        st_lines  <= fin_lines;
                        match_cnt <= next_match;
                        if (next_match >= LOCK_N) begin
                            state_q      <= ST_LOCKED;
                            active_width <= fin_width;
                            active_lines <= fin_lines;
                            stable       <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (vs_rise) begin
                        match_cnt <= next_match;
                        if (!(frame_good && frame_same)) begin
                            state_q  <= ST_MEASURE;
                            stable   <= 1'b0;
                            st_width <= fin_width;
                            st_lines <= fin_lines;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Losing vsync entirely overrides whatever the FSM decided above.
            if (timeout) begin
                state_q <= ST_IDLE;
                stable  <= 1'b0;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_video_timing_detect.sv
// Directed bench for video_timing_detect: lock/unlock/relock, format change,
// vsync timeout, reset with pass-through, saturation and frame counter wrap.
module tb_video_timing_detect;
    import video_timing_detect_pkg::*;

    localparam logic [15:0] FC_INIT = 16'hFFFD;

    logic        clk = 1'b0;
    logic        rst, de, hsync, vsync;
    logic [23:0] rgb_in;
    logic [23:0] rgb_out, rgb_out2;
    logic        de_out, hsync_out, vsync_out, de_out2, hsync_out2, vsync_out2;
    logic [11:0] active_width, active_lines, active_width2, active_lines2;
    logic        stable, stable2;
    logic [15:0] frame_cnt, frame_cnt2;
    logic [1:0]  state, state2;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_fc, exp_fc2;
    logic        prev_vs;

    // Short timeout and preloaded frame counter so timeout and wrap are reachable quickly.
    video_timing_detect #(.LOCK_FRAMES(2), .TIMEOUT_CYC(1000), .FRAME_CNT_RST(FC_INIT)) dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in), .de(de), .hsync(hsync), .vsync(vsync),
        .rgb_out(rgb_out), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .active_width(active_width), .active_lines(active_lines), .stable(stable),
        .frame_cnt(frame_cnt), .state(state)
    );

    // Default timeout, used where frames are longer than the short timeout.
    video_timing_detect #(.LOCK_FRAMES(2)) dut2 (
        .clk(clk), .rst(rst), .rgb_in(rgb_in), .de(de), .hsync(hsync), .vsync(vsync),
        .rgb_out(rgb_out2), .de_out(de_out2), .hsync_out(hsync_out2), .vsync_out(vsync_out2),
        .active_width(active_width2), .active_lines(active_lines2), .stable(stable2),
        .frame_cnt(frame_cnt2), .state(state2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, update the frame-count model, check the 1-cycle pass-through.
    task automatic drive(input logic r, input logic d, input logic h, input logic v);
        logic [23:0] px;
        px     = 24'($urandom);
        rst    = r;
        de     = d;
        hsync  = h;
        vsync  = v;
        rgb_in = px;
        if (r) begin
            exp_fc  = FC_INIT;
            exp_fc2 = 16'h0000;
            prev_vs = 1'b0;
        end else begin
            if (v && !prev_vs) begin
                exp_fc  = exp_fc + 16'd1;
                exp_fc2 = exp_fc2 + 16'd1;
            end
            prev_vs = v;
        end
        @(posedge clk);
        #1;
        chk("passthru", {5'd0, rgb_out, de_out, hsync_out, vsync_out},
            r ? 32'd0 : {5'd0, px, d, h, v});
    endtask

    task automatic vsync_edge();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});
    endtask

    // Rest of a frame after its vsync rising edge; tail=0 leaves the last DE line
    // running so its fall coincides with the next vsync edge.
    task automatic frame_body(input int w, input int lines, input int odd_line,
                              input int odd_w, input bit tail);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int l = 0; l < lines; l++) begin
            int lw;
            lw = (l == odd_line) ? odd_w : w;
            for (int p = 0; p < lw; p++) drive(1'b0, 1'b1, 1'b0, 1'b0);
            if (tail || (l != lines - 1)) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0);
                drive(1'b0, 1'b0, 1'b1, 1'b0);
                drive(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic chk_fmt(input string tag, input vtd_state_t st, input logic stb,
                           input int aw, input int al);
        chk({tag, ".state"}, {30'd0, state}, 32'(st));
        chk({tag, ".stable"}, {31'd0, stable}, {31'd0, stb});
        chk({tag, ".width"}, {20'd0, active_width}, 32'(aw));
        chk({tag, ".lines"}, {20'd0, active_lines}, 32'(al));
    endtask

    task automatic chk_dut2(input string tag, input vtd_state_t st, input logic stb);
        chk({tag, ".state2"}, {30'd0, state2}, 32'(st));
        chk({tag, ".stable2"}, {31'd0, stable2}, {31'd0, stb});
        chk({tag, ".fc2"}, {16'd0, frame_cnt2}, {16'd0, exp_fc2});
    endtask

    initial begin
        exp_fc  = FC_INIT;
        exp_fc2 = 16'h0000;
        prev_vs = 1'b0;
        rst = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0; rgb_in = '0;

        // Reset state
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_fmt("reset", ST_IDLE, 1'b0, 0, 0);
        chk("reset.fc", {16'd0, frame_cnt}, {16'd0, FC_INIT});
        chk("reset.fc2", {16'd0, frame_cnt2}, 32'd0);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Three identical 8x4 frames: lock at the boundary ending frame 2
        vsync_edge();                      chk_fmt("f1", ST_MEASURE, 1'b0, 0, 0);
        frame_body(8, 4, -1, 0, 1'b1);
        vsync_edge();                      chk_fmt("f2", ST_MEASURE, 1'b0, 0, 0);
        frame_body(8, 4, -1, 0, 1'b1);
        vsync_edge();                      chk_fmt("lock8x4", ST_LOCKED, 1'b1, 8, 4);
        chk("fc_wrap", {16'd0, frame_cnt}, 32'd0);
        frame_body(8, 4, -1, 0, 1'b1);
        vsync_edge();                      chk_fmt("hold8x4", ST_LOCKED, 1'b1, 8, 4);

        // Short third line unlocks, then two good frames relock
        frame_body(8, 4, 2, 7, 1'b1);
        vsync_edge();                      chk_fmt("badline", ST_MEASURE, 1'b0, 8, 4);
        frame_body(8, 4, -1, 0, 1'b1);
        vsync_edge();                      chk_fmt("relock1", ST_MEASURE, 1'b0, 8, 4);
        frame_body(8, 4, -1, 0, 1'b1);
        vsync_edge();                      chk_fmt("relock2", ST_LOCKED, 1'b1, 8, 4);

        // Format change to 16x6
        frame_body(16, 6, -1, 0, 1'b1);
        vsync_edge();                      chk_fmt("chg1", ST_MEASURE, 1'b0, 8, 4);
        frame_body(16, 6, -1, 0, 1'b1);
        vsync_edge();                      chk_fmt("chg2", ST_LOCKED, 1'b1, 16, 6);

        // vsync lost: still locked after 999 cycles, idle at cycle 1000
        repeat (999) drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk_fmt("to999", ST_LOCKED, 1'b1, 16, 6);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("to1000.state", {30'd0, state}, 32'(ST_IDLE));
        chk("to1000.stable", {31'd0, stable}, 32'd0);

        // Last DE fall of each frame coincides with the vsync edge
        vsync_edge();                      chk("coin0", {30'd0, state}, 32'(ST_MEASURE));
        frame_body(8, 4, -1, 0, 1'b0);
        vsync_edge();                      chk("coin1", {31'd0, stable}, 32'd0);
        frame_body(8, 4, -1, 0, 1'b0);
        vsync_edge();                      chk_fmt("coin_lock", ST_LOCKED, 1'b1, 8, 4);

        // Random video with a reset pulse in the middle of a DE run
        for (int i = 0; i < 80; i++)
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk_fmt("midrst", ST_IDLE, 1'b0, 0, 0);
        chk("midrst.fc", {16'd0, frame_cnt}, {16'd0, FC_INIT});
        for (int i = 0; i < 120; i++)
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("rand.fc", {16'd0, frame_cnt}, {16'd0, exp_fc});
        chk("rand.fc2", {16'd0, frame_cnt2}, {16'd0, exp_fc2});

        // 5000-px DE runs saturate the run counter: frames are bad, never lock
        repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
        vsync_edge();                      chk_dut2("sat0", ST_MEASURE, 1'b0);
        for (int f = 0; f < 3; f++) begin
            frame_body(5000, 1, -1, 0, 1'b1);
            vsync_edge();                  chk_dut2("sat", ST_MEASURE, 1'b0);
        end

        // Frames without any DE line are bad as well
        for (int f = 0; f < 3; f++) begin
            frame_body(8, 0, -1, 0, 1'b1);
            vsync_edge();                  chk_dut2("nolines", ST_MEASURE, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_timing_detect.md
VIDEO_TIMING_DETECT -- requirements
Module: video_timing_detect

Interface
REQ-001 The block SHALL have parameter LOCK_FRAMES, default 2, giving the number of consecutive identical frames required to assert stable.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 2**24, giving the number of clk cycles without a vsync rising edge that forces unlock.
REQ-003 clk  in  1  pixel clock; the only clock; all logic rises on it.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 rgb_in  in  24  pixel {blue, green, red}.
REQ-006 de / hsync / vsync  in  1 each  data enable and syncs; vsync pulse is active-high.
REQ-007 rgb_out / de_out / hsync_out / vsync_out  out  24/1/1/1  pass-through video.
REQ-008 active_width  out  12  DE-high cycles per line of the locked format.
REQ-009 active_lines  out  12  DE lines per frame of the locked format.
REQ-010 stable  out  1  format locked.
REQ-011 frame_cnt  out  16  count of vsync rising edges.

Function
REQ-012 Pass-through outputs SHALL equal the inputs delayed by exactly 1 clk, unmodified in every state.
REQ-013 A frame boundary SHALL be a vsync rising edge (vsync=1 with the previous-cycle vsync=0).
REQ-014 frame_cnt SHALL increment by 1 on every frame boundary and wrap from 0xFFFF to 0.
REQ-015 The run counter SHALL count consecutive DE-high cycles and SHALL saturate at 4095.
REQ-016 On each DE falling edge, the line counter (saturating at 4095) SHALL increment.
REQ-017 On the first DE falling edge of a frame, the run length SHALL be recorded as the frame width.
REQ-018 On each later DE falling edge in the same frame, a run length different from the frame width SHALL mark the frame bad.
REQ-019 Saturation of the run counter or the line counter SHALL mark the frame bad.
REQ-020 States SHALL be IDLE, MEASURE and LOCKED.
- IDLE -> MEASURE on the first frame boundary; counters are cleared.
REQ-021 At each frame boundary in MEASURE, the just-ended frame SHALL be evaluated as follows.
- Good, nonzero and equal to the stored (width, lines): match count +1.
- Otherwise: store the new (width, lines) and set match count to 1; a bad or zero frame sets it to 0.
REQ-022 When the match count reaches LOCK_FRAMES, the FSM SHALL enter LOCKED.
- Same cycle: active_width and active_lines are loaded and stable is asserted.
REQ-023 In LOCKED, a frame that is bad or differs SHALL deassert stable on the cycle after the boundary.
- Next state is MEASURE, with the new frame stored and match count set to 1, or 0 if the frame is bad.
- active_width and active_lines hold their last locked values.
REQ-024 If TIMEOUT_CYC cycles pass with no frame boundary in any state, the FSM SHALL go to IDLE and deassert stable.
REQ-025 A DE falling edge in the same cycle as a frame boundary SHALL be accounted to the ending frame; the new frame's counters start at zero the next cycle.
REQ-026 A frame with zero DE lines SHALL be treated as a bad frame.

Reset
REQ-027 While rst=1, the block SHALL set all pass-through outputs, active_width, active_lines, stable, frame_cnt and all internal counters to 0, and the state to IDLE.
REQ-028 rst asserted mid-frame SHALL discard any partial measurement; after release, measurement restarts from IDLE at the next frame boundary.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE, MEASURE, LOCKED) and the 12-bit count width constant.
REQ-030 One sub-module, video_edge_det, SHALL be instantiated three times and provide the registered previous value plus rise and fall pulses for de, hsync and vsync.

Verification
REQ-031 Three identical frames of 8 px x 4 lines, LOCK_FRAMES=2 -> stable=1 after the boundary ending frame 2; active_width=8, active_lines=4.
REQ-032 Locked 8x4, then one frame with line 3 of 7 px -> stable=0 the cycle after that frame's boundary; outputs stay 8/4; relock after 2 good 8x4 frames.
REQ-033 Locked 8x4, then switch to 16x6 frames -> unlock, then lock at 16/6 after 2 frames; frame_cnt increments once per frame throughout.
REQ-034 vsync held 0 for TIMEOUT_CYC (overridden to 1000) cycles while locked -> stable=0 and state IDLE at cycle 1000.
REQ-035 Random pixels/syncs, rst pulsed mid-line -> outputs 0 during rst; pass-through always equals the input delayed by 1 cycle.
REQ-036 A 5000-px DE run -> frame bad; never locks; frame_cnt still wraps 0xFFFF -> 0 when preloaded via 65536 boundaries.
